aes_decrypt_iter: RTL and testbench

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_gcm_pkg.sv | 38 +++
 rtl/aes_inv_round.sv | 57 +++++
 rtl/aes_decrypt_iter.sv | 98 +++++++++
 tb/tb_aes_decrypt_iter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_gcm_pkg.sv
// Shared AES definitions: block/schedule sizes, decrypt FSM states, inverse S-box and GF(2^8) helper.
package aes_gcm_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_NR      = 10;
    localparam int KEY_SCHED_W = 1408;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_fsm_e;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES-128 inverse round, purely combinational:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (mix skipped on the last round).
// Byte i of the block sits at bits [8i : 8i+7]; column c holds bytes 4c..4c+3 (row = i mod 4).
module aes_inv_round
    import aes_gcm_pkg::*;
(
    input  logic [0:AES_BLOCK_W-1] state,
    input  logic [0:AES_BLOCK_W-1] round_key,
    input  logic                   last_round,
    output logic [0:AES_BLOCK_W-1] next_state
);

    // Multiplies one column by the inverse MixColumns matrix {0e 0b 0d 09}.
    function automatic logic [0:31] inv_mix_col(input logic [0:31] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a     = col[8*i +: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Row r is rotated right by r, so output (r,c) reads input (r, c-r mod 4).
    function automatic logic [0:AES_BLOCK_W-1] inv_round_fn(input logic [0:AES_BLOCK_W-1] s,
                                                            input logic [0:AES_BLOCK_W-1] rk,
                                                            input logic                   last);
        logic [0:AES_BLOCK_W-1] res;
        logic [0:31]            col;
        int                     src;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            col = '0;
            for (int r = 0; r < 4; r++) begin
                src             = 4 * ((c - r + 4) % 4) + r;
                col[8*r +: 8]   = INV_SBOX[s[8*src +: 8]] ^ rk[32*c + 8*r +: 8];
            end
            res[32*c +: 32] = last ? col : inv_mix_col(col);
        end
        return res;
    endfunction

    assign next_state = inv_round_fn(state, round_key, last_round);

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock through a single shared round unit.
// Accepts a block plus its expanded key, produces the plaintext 10 edges later and holds it
// until the consumer takes it; a new block may be accepted on the same edge as the handoff.
module aes_decrypt_iter
    import aes_gcm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [0:AES_BLOCK_W-1] i_cipher_text,
    input  logic [0:KEY_SCHED_W-1] i_key_schedule,
    input  logic                   i_valid,
    output logic                   o_in_ready,
    output logic [0:AES_BLOCK_W-1] o_plain_text,
    output logic                   o_valid,
    input  logic                   i_out_ready,
    output logic                   o_busy
);

    aes_fsm_e               fsm_q, fsm_d;
    logic [3:0]             rnd_q;
    logic [0:AES_BLOCK_W-1] state_q;
    logic [0:KEY_SCHED_W-1] ks_q;
    logic [0:AES_BLOCK_W-1] round_key;
    logic [0:AES_BLOCK_W-1] round_out;
    logic                   last_round;
    logic                   load_in;

    // The counter never exceeds 9 while in ROUND, so the slice always lands inside the schedule.
    assign round_key  = ks_q[AES_BLOCK_W*int'(rnd_q) +: AES_BLOCK_W];
    assign last_round = (rnd_q == 4'd0);

    aes_inv_round u_inv_round (
        .state      (state_q),
        .round_key  (round_key),
        .last_round (last_round),
        .next_state (round_out)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    // Next-state logic and handshake outputs; DONE can hand off and accept on the same edge.
    always_comb begin
        fsm_d      = fsm_q;
        o_in_ready = 1'b0;
        o_valid    = 1'b0;
        o_busy     = 1'b0;
        load_in    = 1'b0;
        case (fsm_q)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_valid) begin
                    load_in = 1'b1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                o_busy = 1'b1;
                if (last_round) fsm_d = DONE;
            end
            DONE: begin
                o_busy     = 1'b1;
                o_valid    = 1'b1;
                o_in_ready = i_out_ready;
                if (i_out_ready) begin
                    load_in = i_valid;
                    fsm_d   = i_valid ? ROUND : IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Block state and round counter: initial AddRoundKey with rk10 on load, one round per edge after.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
            rnd_q   <= 4'd0;
        end else if (load_in) begin
            state_q <= i_cipher_text ^ i_key_schedule[AES_NR*AES_BLOCK_W +: AES_BLOCK_W];
            rnd_q   <= 4'(AES_NR - 1);
        end else if (fsm_q == ROUND) begin
            state_q <= round_out;
            if (!last_round) rnd_q <= rnd_q - 4'd1;
        end
    end

    // Private copy of the key schedule so upstream may change it while a block is in flight.
    always_ff @(posedge clk) begin
        if (load_in) ks_q <= i_key_schedule;
    end

    assign o_plain_text = state_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: independent AES-128 encrypt/key-expansion model
// (S-box derived from GF(2^8) inversion), scoreboard queue filled at acceptance, drained at output.
module tb_aes_decrypt_iter;

    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [0:127]    i_cipher_text = '0;
    logic [0:1407]   i_key_schedule = '0;
    logic            i_valid = 1'b0;
    logic            i_out_ready = 1'b1;
    logic            o_in_ready;
    logic [0:127]    o_plain_text;
    logic            o_valid;
    logic            o_busy;

    aes_decrypt_iter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cipher_text  (i_cipher_text),
        .i_key_schedule (i_key_schedule),
        .i_valid        (i_valid),
        .o_in_ready     (o_in_ready),
        .o_plain_text   (o_plain_text),
        .o_valid        (o_valid),
        .i_out_ready    (i_out_ready),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:1407] key_expand(input logic [0:127] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1407] ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t  = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1407] ks);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] res;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ ks[8*i +: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = t[4*((c+r)%4)+r];
            if (rd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*rd + 8*i +: 8];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [0:1407] rand1408();
        logic [0:1407] v;
        for (int w = 0; w < 44; w++) v[32*w +: 32] = $urandom();
        return v;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [0:127] pt;
        int           acc;
    } sb_entry_t;

    sb_entry_t    sb [$];
    logic [0:127] exp_cur = '0;
    int           cyc = 0;
    int           acc_cnt = 0;
    int           vld_cnt = 0;
    int           last_out = -1;
    bit           lat_done = 1'b0;
    bit           spacing_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                lat_done = 1'b0;
            end else begin
                if (i_valid && o_in_ready) begin
                    sb.push_back('{pt: exp_cur, acc: cyc + 1});
                    acc_cnt++;
                end
                if (o_valid) begin
                    vld_cnt++;
                    chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
                    if (sb.size() != 0) begin
                        if (!lat_done) begin
                            chk("latency", 128'(cyc - sb[0].acc), 128'(10));
                            lat_done = 1'b1;
                        end
                        if (i_out_ready) begin
                            chk("plain_text", o_plain_text, sb[0].pt);
                            if (spacing_on && last_out >= 0)
                                chk("spacing", 128'(cyc - last_out), 128'(11));
                            last_out = cyc;
                            void'(sb.pop_front());
                            lat_done = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic send(input logic [0:127] ct, input logic [0:1407] ks,
                        input logic [0:127] pt, input bit keep_valid);
        int n;
        n = 0;
        i_cipher_text  = ct;
        i_key_schedule = ks;
        exp_cur        = pt;
        i_valid        = 1'b1;
        @(negedge clk);
        while (!o_in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) chk("accept_timeout", 128'(o_in_ready), 128'(1));
        @(posedge clk);
        #1;
        if (!keep_valid) i_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [0:1407] c1_ks;
        logic [0:1407] ks_arr [4];
        logic [0:127]  ct_arr [4];
        logic [0:127]  pt_arr [4];
        logic [0:127]  key, pt;
        logic [0:1407] ks;
        int            n, a0, v0;

        build_sbox();
        c1_ks = key_expand(C1_KEY);
        chk("model_c1", encrypt(C1_PT, c1_ks), C1_CT);

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", 128'(o_valid), 128'(0));
        chk("rst_o_busy", 128'(o_busy), 128'(0));
        chk("rst_o_in_ready", 128'(o_in_ready), 128'(1));
        chk("rst_o_plain_text", o_plain_text, 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FIPS-197 C.1 decrypt
        send(C1_CT, c1_ks, C1_PT, 1'b0);
        wait_drain(30);

        // output stall for 20 cycles, then release with no new input
        i_out_ready = 1'b0;
        send(C1_CT, c1_ks, C1_PT, 1'b0);
        n = 0;
        @(negedge clk);
        while (!o_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 20; k++) begin
            chk("stall_valid", 128'(o_valid), 128'(1));
            chk("stall_pt", o_plain_text, C1_PT);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        i_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("release_in_ready", 128'(o_in_ready), 128'(1));
        chk("release_busy", 128'(o_busy), 128'(0));
        chk("release_valid", 128'(o_valid), 128'(0));
        chk("release_sb_empty", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;

        // back-to-back stream of 4 blocks
        for (int j = 0; j < 4; j++) begin
            pt_arr[j] = rand128();
            ks_arr[j] = key_expand(rand128());
            ct_arr[j] = encrypt(pt_arr[j], ks_arr[j]);
        end
        spacing_on = 1'b1;
        last_out   = -1;
        a0         = acc_cnt;
        for (int j = 0; j < 4; j++) send(ct_arr[j], ks_arr[j], pt_arr[j], j < 3);
        wait_drain(40);
        spacing_on = 1'b0;
        chk("b2b_accepts", 128'(acc_cnt - a0), 128'(4));

        // inputs churn every cycle during ROUND with i_valid held high
        a0 = acc_cnt;
        send(C1_CT, c1_ks, C1_PT, 1'b1);
        for (int k = 0; k < 10; k++) begin
            i_cipher_text  = rand128();
            i_key_schedule = rand1408();
            i_valid        = 1'b1;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        wait_drain(30);
        chk("single_accept", 128'(acc_cnt - a0), 128'(1));

        // reset while the round counter is 5
        send(C1_CT, c1_ks, C1_PT, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v0 = vld_cnt;
        @(negedge clk);
        chk("midrst_valid", 128'(o_valid), 128'(0));
        chk("midrst_busy", 128'(o_busy), 128'(0));
        chk("midrst_in_ready", 128'(o_in_ready), 128'(1));
        repeat (12) @(negedge clk);
        #1;
        chk("midrst_no_valid", 128'(vld_cnt - v0), 128'(0));
        @(posedge clk);
        #1;
        send(C1_CT, c1_ks, C1_PT, 1'b0);
        wait_drain(30);

        // random encrypt-with-model / decrypt-in-DUT
        for (int it = 0; it < 1000; it++) begin
            key = rand128();
            pt  = rand128();
            ks  = key_expand(key);
            send(encrypt(pt, ks), ks, pt, 1'b0);
        end
        wait_drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
